comparador_serial: RTL and testbench

- Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands.
- Selectable unsigned/two's-complement mode.
- Compares MSB-first, one bit per clock, and terminates early at the first differing bit.
- Start/valid handshake lets a datapath controller issue comparisons and collect registered maior/menor/igual flags.

---
 rtl/comparador_serial_pkg.sv | 15 +
 rtl/comparador_serial_if.sv | 25 ++
 rtl/comparador1bit_struct.sv | 17 +
 rtl/comparador_serial.sv | 130 +++++++++++++
 tb/tb_comparador_serial.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/comparador_serial_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding and the index-width helper.
package comparador_serial_pkg;

    typedef enum logic {
        OCIOSO  = 1'b0,
        COMPARA = 1'b1
    } estado_t;

    // Width of the bit index for a given operand width (at least one bit).
    function automatic int idx_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// Request/result bundle between a datapath controller (master) and the
// serial comparator (slave).
interface comparador_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sinal;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ocupado;
    logic             valido;
    logic             maior;
    logic             menor;
    logic             igual;

    modport master (
        output start, sinal, a, b,
        input  ocupado, valido, maior, menor, igual
    );

    modport slave (
        input  start, sinal, a, b,
        output ocupado, valido, maior, menor, igual
    );
endinterface

// File: rtl/comparador1bit_struct.sv
// Structural 1-bit magnitude comparator cell: exactly one output is high.
module comparador1bit_struct (
    input  wire a,
    input  wire b,
    output wire maior,
    output wire menor,
    output wire igual
);
    wire na_s;
    wire nb_s;

    not  u_na    (na_s, a);
    not  u_nb    (nb_s, b);
    and  u_maior (maior, a, nb_s);
    and  u_menor (menor, na_s, b);
    xnor u_igual (igual, a, b);
endmodule

// File: rtl/comparador_serial.sv
// Bit-serial MSB-first magnitude comparator with unsigned / two's-complement
// mode. Stops at the first differing bit and reports registered flags with a
// one-cycle valido pulse.
module comparador_serial
    import comparador_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    comparador_serial_if.slave  bus
);
    localparam int             IDX_W    = idx_w(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    estado_t          estado_r;
    estado_t          estado_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sinal_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             valido_r;
    logic             maior_r;
    logic             menor_r;
    logic             igual_r;
    logic             maior_nxt_s;
    logic             menor_nxt_s;
    logic             igual_nxt_s;
    logic             decide_s;
    logic             latch_s;
    logic             swap_s;
    logic             bit_a_s;
    logic             bit_b_s;
    logic             cel_maior_s;
    logic             cel_menor_s;
    logic             cel_igual_s;

    assign bit_a_s = a_r[idx_r];
    assign bit_b_s = b_r[idx_r];

    // In signed mode the sign bit carries inverted weight, so swap there only.
    assign swap_s = sinal_r & (idx_r == IDX_MSB);

    comparador1bit_struct u_bit (
        .a     (bit_a_s),
        .b     (bit_b_s),
        .maior (cel_maior_s),
        .menor (cel_menor_s),
        .igual (cel_igual_s)
    );

    // Next-state, index step and result decision for the current bit.
    always_comb begin
        estado_nxt_s = estado_r;
        idx_nxt_s    = idx_r;
        decide_s     = 1'b0;
        latch_s      = 1'b0;
        maior_nxt_s  = maior_r;
        menor_nxt_s  = menor_r;
        igual_nxt_s  = igual_r;
        case (estado_r)
            OCIOSO: begin
                if (bus.start) begin
                    latch_s      = 1'b1;
                    idx_nxt_s    = IDX_MSB;
                    estado_nxt_s = COMPARA;
                end else begin
                    estado_nxt_s = OCIOSO;
                end
            end
            COMPARA: begin
                if (!cel_igual_s) begin
                    decide_s     = 1'b1;
                    maior_nxt_s  = swap_s ? cel_menor_s : cel_maior_s;
                    menor_nxt_s  = swap_s ? cel_maior_s : cel_menor_s;
                    igual_nxt_s  = 1'b0;
                    estado_nxt_s = OCIOSO;
                end else if (idx_r == IDX_ZERO) begin
                    decide_s     = 1'b1;
                    maior_nxt_s  = 1'b0;
                    menor_nxt_s  = 1'b0;
                    igual_nxt_s  = 1'b1;
                    estado_nxt_s = OCIOSO;
                end else begin
                    idx_nxt_s    = idx_r - IDX_ONE;
                    estado_nxt_s = COMPARA;
                end
            end
            default: begin
                estado_nxt_s = OCIOSO;
            end
        endcase
    end

    // State, operand latches, index and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= OCIOSO;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            sinal_r  <= 1'b0;
            idx_r    <= IDX_ZERO;
            valido_r <= 1'b0;
            maior_r  <= 1'b0;
            menor_r  <= 1'b0;
            igual_r  <= 1'b0;
        end else begin
            estado_r <= estado_nxt_s;
            idx_r    <= idx_nxt_s;
            valido_r <= decide_s;
            maior_r  <= maior_nxt_s;
            menor_r  <= menor_nxt_s;
            igual_r  <= igual_nxt_s;
            if (latch_s) begin
                a_r     <= bus.a;
                b_r     <= bus.b;
                sinal_r <= bus.sinal;
            end
        end
    end

    assign bus.ocupado = (estado_r == COMPARA);
    assign bus.valido  = valido_r;
    assign bus.maior   = maior_r;
    assign bus.menor   = menor_r;
    assign bus.igual   = igual_r;
endmodule

// File: tb/tb_comparador_serial.sv
// Directed, scoreboard-based bench for comparador_serial (WIDTH = 8).
module tb_comparador_serial;
    localparam int WIDTH = 8;
    localparam logic [2:0] F_MAIOR = 3'b100;
    localparam logic [2:0] F_MENOR = 3'b010;
    localparam logic [2:0] F_IGUAL = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   t0     = 0;
    exp_t sb_q[$];

    comparador_serial_if #(.WIDTH(WIDTH)) bus ();

    comparador_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request in the current cycle; returns #1 after its sampling edge.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic s,
                         input logic [2:0] f, input int lat);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.sinal = s;
        e.flags   = f;
        e.lat     = lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        t0        = cyc;
        bus.start = 1'b0;
        check("ocupado_after_start", {31'd0, bus.ocupado}, 32'd1);
        check("valido_after_start", {31'd0, bus.valido}, 32'd0);
    endtask

    // Wait (bounded) for valido, then compare against the scoreboard head.
    task automatic wait_result(input string tag);
        exp_t e;
        bit   got = 1'b0;
        for (int i = 0; i < 4 * WIDTH && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.valido) got = 1'b1;
        end
        check({tag, "_valido_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() > 0)}, 32'd1);
        if (got && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_flags"}, {29'd0, bus.maior, bus.menor, bus.igual}, {29'd0, e.flags});
            check({tag, "_latency"}, cyc - t0, e.lat);
            check({tag, "_ocupado_low"}, {31'd0, bus.ocupado}, 32'd0);
        end
    endtask

    // One cycle later: valido must have dropped and the block must be idle.
    task automatic idle_check(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valido_pulse_end"}, {31'd0, bus.valido}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.ocupado}, 32'd0);
    endtask

    task automatic count_valido(input string tag, input int n);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.valido) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    // Directed stimulus sequence.
    initial begin
        bus.start = 1'b0;
        bus.sinal = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
        check("reset_valido", {31'd0, bus.valido}, 32'd0);
        check("reset_flags", {29'd0, bus.maior, bus.menor, bus.igual}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(8'h80, 8'h7F, 1'b0, F_MAIOR, 1);
        wait_result("u_80_7f");
        idle_check("u_80_7f");

        issue(8'h80, 8'h7F, 1'b1, F_MENOR, 1);
        wait_result("s_80_7f");
        idle_check("s_80_7f");

        issue(8'hA5, 8'hA4, 1'b0, F_MAIOR, 8);
        wait_result("u_a5_a4");
        idle_check("u_a5_a4");

        issue(8'h3C, 8'h3C, 1'b0, F_IGUAL, 8);
        wait_result("u_3c_3c");
        idle_check("u_3c_3c");

        // Start re-pulsed while busy, with operands changed: must be ignored.
        issue(8'h01, 8'h00, 1'b0, F_MAIOR, 8);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'hFF;
        bus.sinal = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_result("busy_ignore");
        count_valido("busy_no_extra_valido", 12);

        // Back-to-back: second start issued in the valido cycle.
        issue(8'hF0, 8'h00, 1'b0, F_MAIOR, 1);
        wait_result("b2b_first");
        issue(8'h00, 8'h01, 1'b0, F_MENOR, 8);
        wait_result("b2b_second");
        idle_check("b2b_second");

        // Signed mode, difference below the sign bit compares unsigned.
        issue(8'hFF, 8'hFE, 1'b1, F_MAIOR, 8);
        wait_result("s_ff_fe");
        idle_check("s_ff_fe");

        issue(8'h01, 8'hFF, 1'b1, F_MAIOR, 1);
        wait_result("s_01_ff");
        idle_check("s_01_ff");

        // Asynchronous reset in the middle of an 8-cycle run.
        issue(8'h3C, 8'h3C, 1'b0, F_IGUAL, 8);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ocupado", {31'd0, bus.ocupado}, 32'd0);
        check("abort_valido", {31'd0, bus.valido}, 32'd0);
        check("abort_flags", {29'd0, bus.maior, bus.menor, bus.igual}, 32'd0);
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        count_valido("abort_no_valido", 12);

        issue(8'h00, 8'h01, 1'b1, F_MENOR, 8);
        wait_result("after_reset");
        idle_check("after_reset");

        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
